// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and geometry constants for the 64-point radix-2 FFT
package fft_pkg;

  localparam int FFT_N      = 64;
  localparam int FFT_LEVELS = 6;
  localparam int FFT_BFLY   = 32;
  localparam int FFT_ADDR_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PROC,
    DRAIN,
    DONE
  } fft_seq_state_t;

endpackage

// File: rtl/fft_wb_delay.sv
// rtl/fft_wb_delay.sv - LAT-stage delay of {valid, level, iter} aligning write-back with butterfly output
module fft_wb_delay
  import fft_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [FFT_ADDR_W-1:0] issue_level,
  input  logic [FFT_ADDR_W-1:0] issue_iter,
  output logic                  wb_valid,
  output logic [FFT_ADDR_W-1:0] wb_level,
  output logic [FFT_ADDR_W-1:0] wb_iter
);

  logic [LAT-1:0]                 valid_q;
  logic [LAT-1:0][FFT_ADDR_W-1:0] level_q;
  logic [LAT-1:0][FFT_ADDR_W-1:0] iter_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      level_q <= '0;
      iter_q  <= '0;
    end else begin
      valid_q[0] <= issue_valid;
      level_q[0] <= issue_level;
      iter_q[0]  <= issue_iter;
      for (int k = 1; k < LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
        level_q[k] <= level_q[k-1];
        iter_q[k]  <= iter_q[k-1];
      end
    end
  end

  assign wb_valid = valid_q[LAT-1];
  assign wb_level = level_q[LAT-1];
  assign wb_iter  = iter_q[LAT-1];

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - load / six-level butterfly / readout controller for the 64-point FFT core
// Optional cycle_count output is enabled by defining FFT_SEQ_CYCLE_COUNT_EN.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int BFLY_LAT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic                  out_ready,
  output logic                  load,
  output logic                  processing,
  output logic                  done,
  output logic [FFT_ADDR_W-1:0] fft_level,
  output logic [FFT_ADDR_W-1:0] butterfly_iter,
  output logic [FFT_ADDR_W-1:0] load_address,
  output logic [FFT_ADDR_W-1:0] out_address,
  output logic                  rd_bank,
  output logic [FFT_ADDR_W-1:0] wr_level,
  output logic [FFT_ADDR_W-1:0] wr_iter,
  output logic                  we_0,
  output logic                  we_1,
  output logic                  out_valid,
  output logic                  busy
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]           cycle_count
`endif
);

  localparam logic [FFT_ADDR_W-1:0] LAST_ADDR  = FFT_ADDR_W'(FFT_N - 1);
  localparam logic [FFT_ADDR_W-1:0] LAST_ITER  = FFT_ADDR_W'(FFT_BFLY - 1);
  localparam logic [FFT_ADDR_W-1:0] LAST_LEVEL = FFT_ADDR_W'(FFT_LEVELS - 1);
  localparam logic [3:0]            DRAIN_LAST = 4'(BFLY_LAT - 1);

  fft_seq_state_t state, state_next;
  logic [3:0]     drain_cnt;
  logic           wb_valid;

  fft_wb_delay #(.LAT(BFLY_LAT)) u_wb_delay (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (state == PROC),
    .issue_level (fft_level),
    .issue_iter  (butterfly_iter),
    .wb_valid    (wb_valid),
    .wb_level    (wr_level),
    .wb_iter     (wr_iter)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    processing = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    // Level L reads bank L[0] and writes the opposite bank, so level 5 lands in bank 0.
    we_0       = wb_valid & wr_level[0];
    we_1       = wb_valid & ~wr_level[0];
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        load = 1'b1;
        we_0 = sample_valid | (wb_valid & wr_level[0]);
        if (sample_valid && load_address == LAST_ADDR) state_next = PROC;
      end
      PROC: begin
        processing = 1'b1;
        if (butterfly_iter == LAST_ITER) state_next = DRAIN;
      end
      DRAIN: begin
        processing = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_next = (fft_level == LAST_LEVEL) ? DONE : PROC;
      end
      DONE: begin
        done = 1'b1;
        if (out_ready && out_address == LAST_ADDR) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fft_level      <= '0;
      butterfly_iter <= '0;
      load_address   <= '0;
      out_address    <= '0;
      drain_cnt      <= '0;
      out_valid      <= 1'b0;
    end else begin
      // RAM bank 0 has one cycle of read latency behind each accepted address.
      out_valid <= (state == DONE) && out_ready;
      unique case (state)
        IDLE: begin
          if (start) begin
            load_address   <= '0;
            fft_level      <= '0;
            butterfly_iter <= '0;
          end
        end
        LOAD: begin
          if (sample_valid) begin
            load_address <= load_address + 1'b1;
            if (load_address == LAST_ADDR) begin
              fft_level      <= '0;
              butterfly_iter <= '0;
            end
          end
        end
        PROC: begin
          drain_cnt      <= '0;
          butterfly_iter <= (butterfly_iter == LAST_ITER) ? '0 : butterfly_iter + 1'b1;
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            if (fft_level != LAST_LEVEL) fft_level   <= fft_level + 1'b1;
            else                         out_address <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_address <= out_address + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_bank = fft_level[0];

`ifdef FFT_SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == IDLE && start) begin
      cycle_count <= '0;
    end else if ((state == LOAD || state == PROC || state == DRAIN) && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - directed self-checking bench for fft_sequencer (BFLY_LAT = 3)
module tb_fft_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sample_valid;
  logic       out_ready;
  logic       load;
  logic       processing;
  logic       done;
  logic [5:0] fft_level;
  logic [5:0] butterfly_iter;
  logic [5:0] load_address;
  logic [5:0] out_address;
  logic       rd_bank;
  logic [5:0] wr_level;
  logic [5:0] wr_iter;
  logic       we_0;
  logic       we_1;
  logic       out_valid;
  logic       busy;
`ifdef FFT_SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  int errors = 0;
  int checks = 0;

  fft_sequencer #(.BFLY_LAT(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .sample_valid   (sample_valid),
    .out_ready      (out_ready),
    .load           (load),
    .processing     (processing),
    .done           (done),
    .fft_level      (fft_level),
    .butterfly_iter (butterfly_iter),
    .load_address   (load_address),
    .out_address    (out_address),
    .rd_bank        (rd_bank),
    .wr_level       (wr_level),
    .wr_iter        (wr_iter),
    .we_0           (we_0),
    .we_1           (we_1),
    .out_valid      (out_valid),
    .busy           (busy)
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    ,
    .cycle_count    (cycle_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({load, processing, done, rd_bank, we_0, we_1, out_valid} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000", {load, processing, done, rd_bank, we_0, we_1, out_valid});
    end
    checks++;
    if ({fft_level, butterfly_iter, load_address, out_address, wr_level, wr_iter} !== 36'd0) begin
      errors++; $display("FAIL reset_counters got %h want 0", {fft_level, butterfly_iter, load_address, out_address, wr_level, wr_iter});
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_gapped_load();
    @(negedge clk); start = 1'b1; #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (load !== 1'b1 || load_address !== 6'd0) begin
      errors++; $display("FAIL load_entry got load=%b addr=%0d want load=1 addr=0", load, load_address);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); sample_valid = 1'b1; #1;
      checks++;
      if (load_address !== 6'(i) || we_0 !== 1'b1 || we_1 !== 1'b0) begin
        errors++; $display("FAIL load_valid got addr=%0d we0=%b we1=%b want addr=%0d we0=1 we1=0", load_address, we_0, we_1, i);
      end
      @(negedge clk); sample_valid = 1'b0; #1;
      if (i < 63) begin
        checks++;
        if (load !== 1'b1 || we_0 !== 1'b0 || load_address !== 6'(i + 1)) begin
          errors++; $display("FAIL load_gap got load=%b we0=%b addr=%0d want load=1 we0=0 addr=%0d", load, we_0, load_address, i + 1);
        end
      end
    end
    checks++;
    if (processing !== 1'b1 || load !== 1'b0 || fft_level !== 6'd0 || butterfly_iter !== 6'd0) begin
      errors++; $display("FAIL proc_entry got proc=%b load=%b level=%0d iter=%0d want 1 0 0 0", processing, load, fft_level, butterfly_iter);
    end
  endtask

  task automatic test_full_transform();
    int c, lvl, pos, ilvl, ipos;
    logic exp_v;
    logic [1:0] exp_we;
    int wr_cnt[6];
    int last_wr[6];
    int first_rd[6];
    for (int l = 0; l < 6; l++) begin wr_cnt[l] = 0; last_wr[l] = -1; first_rd[l] = -1; end
    c = 0;
    while (done !== 1'b1 && c < 400) begin
      lvl = c / 35;
      pos = c % 35;
      checks++;
      if (processing !== 1'b1 || fft_level !== 6'(lvl) || butterfly_iter !== 6'((pos < 32) ? pos : 0)) begin
        errors++; $display("FAIL proc_read cycle %0d got proc=%b level=%0d iter=%0d want 1 %0d %0d", c, processing, fft_level, butterfly_iter, lvl, (pos < 32) ? pos : 0);
      end
      checks++;
      if (rd_bank !== 1'(lvl & 1)) begin errors++; $display("FAIL rd_bank cycle %0d got %b want %0d", c, rd_bank, lvl & 1); end
      exp_v  = (c >= 3) && (((c - 3) % 35) < 32);
      ilvl   = (c - 3) / 35;
      ipos   = (c - 3) % 35;
      exp_we = exp_v ? {1'(ilvl & 1), ~1'(ilvl & 1)} : 2'b00;
      checks++;
      if ({we_0, we_1} !== exp_we) begin errors++; $display("FAIL we cycle %0d got %b want %b", c, {we_0, we_1}, exp_we); end
      if (exp_v) begin
        checks++;
        if (wr_level !== 6'(ilvl) || wr_iter !== 6'(ipos)) begin
          errors++; $display("FAIL wr_addr cycle %0d got level=%0d iter=%0d want %0d %0d", c, wr_level, wr_iter, ilvl, ipos);
        end
      end
      if ((we_0 | we_1) && wr_level < 6) begin wr_cnt[int'(wr_level)]++; last_wr[int'(wr_level)] = c; end
      if (processing && fft_level < 6 && first_rd[int'(fft_level)] < 0) first_rd[int'(fft_level)] = c;
      @(negedge clk); #1;
      c++;
    end
    checks++;
    if (c !== 210 || done !== 1'b1) begin errors++; $display("FAIL proc_to_done got %0d cycles want 210", c); end
    for (int l = 0; l < 6; l++) begin
      checks++;
      if (wr_cnt[l] !== 32) begin errors++; $display("FAIL level_writes level %0d got %0d want 32", l, wr_cnt[l]); end
    end
    for (int l = 0; l < 5; l++) begin
      checks++;
      if (!(first_rd[l+1] > last_wr[l])) begin
        errors++; $display("FAIL raw_hazard level %0d first read %0d want after last write %0d", l + 1, first_rd[l+1], last_wr[l]);
      end
    end
  endtask

  task automatic test_readout_stalls();
    int acc, k;
    logic r, prev;
    checks++;
    if (done !== 1'b1 || out_address !== 6'd0 || out_valid !== 1'b0 || processing !== 1'b0) begin
      errors++; $display("FAIL done_entry got done=%b addr=%0d ov=%b proc=%b want 1 0 0 0", done, out_address, out_valid, processing);
    end
    acc = 0; k = 0; prev = 1'b0;
    while (acc < 64 && k < 300) begin
      @(negedge clk);
      r = ((k * 5 + 3) % 7) < 4;
      out_ready = r;
      start = r && (acc == 63);
      #1;
      checks++;
      if (out_address !== 6'(acc) || out_valid !== prev || done !== 1'b1) begin
        errors++; $display("FAIL readout step %0d got addr=%0d ov=%b done=%b want %0d %b 1", k, out_address, out_valid, done, acc, prev);
      end
      prev = r;
      if (r) acc++;
      k++;
    end
    @(negedge clk); out_ready = 1'b0; start = 1'b0; #1;
    checks++;
    if (acc !== 64 || busy !== 1'b0 || out_valid !== 1'b1 || out_address !== 6'd0) begin
      errors++; $display("FAIL readout_end got acc=%0d busy=%b ov=%b addr=%0d want 64 0 1 0", acc, busy, out_valid, out_address);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || load !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL start_on_exit got ov=%b load=%b busy=%b want 0 0 0", out_valid, load, busy);
    end
  endtask

  task automatic test_mid_reset();
    int k, pulses, busy_seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; sample_valid = 1'b1;
    repeat (64) @(negedge clk);
    sample_valid = 1'b0; #1;
    k = 0;
    while (!(fft_level === 6'd3 && butterfly_iter === 6'd17) && k < 300) begin
      @(negedge clk); #1; k++;
    end
    checks++;
    if (k !== 122 || we_0 !== 1'b1) begin errors++; $display("FAIL reach_l3_i17 got cycle=%0d we0=%b want 122 1", k, we_0); end
    reset = 1'b1; #1;
    checks++;
    if (busy !== 1'b0 || we_0 !== 1'b0 || we_1 !== 1'b0 || fft_level !== 6'd0 || processing !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%b we=%b%b level=%0d proc=%b want 0 00 0 0", busy, we_0, we_1, fft_level, processing);
    end
    @(negedge clk); reset = 1'b0;
    pulses = 0; busy_seen = 0;
    repeat (60) begin
      @(negedge clk); #1;
      if (we_0 | we_1) pulses++;
      if (busy) busy_seen++;
    end
    checks++;
    if (pulses !== 0 || busy_seen !== 0) begin errors++; $display("FAIL post_reset_writes got we=%0d busy=%0d want 0 0", pulses, busy_seen); end
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; sample_valid = 1'b1;
    repeat (64) @(negedge clk);
    sample_valid = 1'b0; #1;
    checks++;
    if (processing !== 1'b1 || fft_level !== 6'd0 || butterfly_iter !== 6'd0) begin
      errors++; $display("FAIL b2b_proc_entry got proc=%b level=%0d iter=%0d want 1 0 0", processing, fft_level, butterfly_iter);
    end
    c = 0;
    while (done !== 1'b1 && c < 400) begin
      start = (c == 5);
      @(negedge clk); #1;
      c++;
    end
    start = 1'b0;
    checks++;
    if (c !== 210) begin errors++; $display("FAIL b2b_proc_to_done got %0d want 210", c); end
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycle_count !== 16'd274) begin errors++; $display("FAIL cycle_count_done got %0d want 274", cycle_count); end
`endif
    out_ready = 1'b1;
    repeat (32) @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || out_address !== 6'd32 || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_readout_mid got done=%b addr=%0d ov=%b want 1 32 1", done, out_address, out_valid);
    end
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycle_count !== 16'd274) begin errors++; $display("FAIL cycle_count_hold got %0d want 274", cycle_count); end
`endif
    repeat (32) @(negedge clk);
    out_ready = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_idle got busy=%b ov=%b want 0 1", busy, out_valid); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (load !== 1'b1 || load_address !== 6'd0) begin
      errors++; $display("FAIL restart_load got load=%b addr=%0d want 1 0", load, load_address);
    end
`ifdef FFT_SEQ_CYCLE_COUNT_EN
    checks++;
    if (cycle_count !== 16'd0) begin errors++; $display("FAIL cycle_count_clear got %0d want 0", cycle_count); end
`endif
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    sample_valid = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_gapped_load();
    test_full_transform();
    test_readout_stalls();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Top-level controller for the 64-point radix-2 FFT core. Steps the transform through sample loading, six butterfly levels and result read-out. Drives the mode flags and counters consumed by the address generation unit, and the write-enables of the two ping-pong sample RAMs. Tracks butterfly pipeline latency so write-back addresses line up with data and no level reads a location before the previous level has written it.

## Interface

Parameters:
- `BFLY_LAT`, default 3: cycles from read-address issue to butterfly write-back (RAM read plus butterfly pipeline); legal range 1..8.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high; returns block to IDLE.
- `start`, input, 1: pulse in IDLE begins a transform; ignored in all other states.
- `sample_valid`, input, 1: one input sample presented this cycle (LOAD only).
- `out_ready`, input, 1: consumer accepts one result address this cycle (DONE only).
- `load`, output, 1: high in LOAD.
- `processing`, output, 1: high in PROC and DRAIN.
- `done`, output, 1: high in DONE.
- `fft_level`, output, 6: read-side level 0..5.
- `butterfly_iter`, output, 6: read-side butterfly index 0..31.
- `load_address`, output, 6: natural-order sample index 0..63.
- `out_address`, output, 6: result index 0..63.
- `rd_bank`, output, 1: bank read this level, `fft_level[0]`.
- `wr_level`, output, 6: `fft_level` delayed `BFLY_LAT` cycles.
- `wr_iter`, output, 6: `butterfly_iter` delayed `BFLY_LAT` cycles.
- `we_0`, output, 1: write-enable, RAM bank 0.
- `we_1`, output, 1: write-enable, RAM bank 1.
- `out_valid`, output, 1: result data on RAM bank 0 output is valid.
- `busy`, output, 1: state is not IDLE.

## Operation

- States are IDLE, LOAD, PROC, DRAIN and DONE. All outputs reset to 0; state resets to IDLE.
- **IDLE to LOAD:** `start` moves the block to LOAD on the next edge; `load_address` is 0.
- **LOAD:**
  - In each cycle with `sample_valid`: `we_0` = 1 combinationally, and `load_address` increments.
  - `sample_valid` at address 63 moves to PROC with level 0 and iter 0.
  - With no `sample_valid`, the block holds.
- **PROC:** issues one butterfly per cycle and increments `butterfly_iter`. At iter 31 the block moves to DRAIN and iter wraps to 0.
- **DRAIN:**
  - Holds for exactly `BFLY_LAT` cycles, timed by a drain counter.
  - Then, if `fft_level` < 5: `fft_level` increments and the block returns to PROC.
  - Otherwise it moves to DONE with `out_address` = 0.
- **Write pipeline:**
  - A `BFLY_LAT`-deep shift register carries {valid, level, iter}; valid is set on every PROC cycle.
  - `we_0` = valid_d & wr_level[0]; `we_1` = valid_d & ~wr_level[0]. Level L reads bank L[0] and writes the other bank, so the final result lands in bank 0.
  - `wr_level` and `wr_iter` come from the delayed stage.
- **DONE:**
  - Each cycle with `out_ready`: `out_address` increments and `out_valid` is registered high for the next cycle (one-cycle RAM read latency).
  - `out_ready` at address 63 moves to IDLE. The last `out_valid` pulse occurs in the first IDLE cycle.
- **Counter widths:** all counters are 6-bit. `butterfly_iter` never exceeds 31, and no counter increments outside its own state.
- **Reset at any time:** state goes to IDLE, counters to 0, the pipeline valid bits are cleared, and no write-enable fires afterwards.

## Timing

- LOAD takes 64 accepted samples; throughput is one sample per cycle.
- Processing takes 6 × (32 + `BFLY_LAT`) cycles from the first PROC cycle to the first DONE cycle (210 for `BFLY_LAT` = 3).
- **Last write-back of a level:**
  - Occurs `BFLY_LAT` cycles after its final issue, i.e. on the last DRAIN cycle.
  - The next level's first read follows one cycle later, so there is no read-after-write hazard.
- `start` asserted in any non-IDLE state has no effect. A `start` coincident with the DONE to IDLE edge is ignored.
- `sample_valid` outside LOAD and `out_ready` outside DONE are ignored.

## Configuration

- **Macro `FFT_SEQ_CYCLE_COUNT_EN`:**
  - Defined: adds output `cycle_count` [15:0]. It clears on LOAD entry, increments every cycle until DONE entry, saturates at 0xFFFF, holds until the next `start`, and resets to 0.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure

- **Shared package `fft_pkg`:**
  - State enum `fft_seq_state_t`.
  - Constants `FFT_N` = 64, `FFT_LEVELS` = 6, `FFT_BFLY` = 32, `FFT_ADDR_W` = 6.
- **One sub-module, `fft_wb_delay`:** the parameterized `BFLY_LAT`-stage shift register for {valid, level, iter}, with asynchronous reset clearing the valid bits.

## Test plan

- **Reset value:** assert reset with no stimulus; check all outputs 0 and `busy` = 0.
- **Gapped load:** `start`, then 64 `sample_valid` pulses with one-cycle gaps. Expect:
  - `load_address` 0..63 in order;
  - `we_0` only on valid cycles;
  - PROC entered with level 0, iter 0.
- **Full transform, `BFLY_LAT` = 3:**
  - Expect 210 cycles from PROC to DONE.
  - Per level: 32 `we` pulses on bank ~L[0], with `wr_iter` 0..31 lagging `butterfly_iter` by 3.
  - No read issued before the prior level's last write.
- **Readout with stalls:** in DONE, toggle `out_ready` randomly. Expect:
  - `out_address` 0..63 advancing only on ready;
  - `out_valid` one cycle after each accept;
  - IDLE after 64 accepts.
- **Mid-operation reset:** assert reset at level 3, iter 17, with writes in flight. Expect IDLE immediately and no `we_0`/`we_1` pulse afterwards. A new `start` then completes normally.
- **Cycle count (`FFT_SEQ_CYCLE_COUNT_EN`, back-to-back load):** `cycle_count` = 64 + 210 = 274 at DONE. It holds through readout and clears on the next LOAD entry.
